// File: rtl/rom_dl_pkg.sv
// Shared definitions for the sprint1 ROM download path: controller states,
// region map and the address-in-region helper used by the decoder.
package rom_dl_pkg;

    typedef enum logic [2:0] {
        ST_EMPTY = 3'd0,
        ST_LOAD  = 3'd1,
        ST_CHECK = 3'd2,
        ST_HOLD  = 3'd3,
        ST_RUN   = 3'd4,
        ST_FAIL  = 3'd5
    } dl_state_t;

    // Bit positions inside the one-hot region write enable.
    localparam int REG_PROG = 0;
    localparam int REG_PF   = 1;
    localparam int REG_MOB  = 2;
    localparam int REG_PROM = 3;
    localparam int NUM_REGIONS = 4;

    localparam logic [24:0] PROG_BASE = 25'h000_0000;
    localparam logic [24:0] PROG_SIZE = 25'h000_2000;
    localparam logic [24:0] PF_BASE   = 25'h000_2000;
    localparam logic [24:0] PF_SIZE   = 25'h000_0800;
    localparam logic [24:0] MOB_BASE  = 25'h000_2800;
    localparam logic [24:0] MOB_SIZE  = 25'h000_0800;
    localparam logic [24:0] PROM_BASE = 25'h000_3000;
    localparam logic [24:0] PROM_SIZE = 25'h000_0200;

    localparam int TOTAL_BYTES = 'h3200;

    // Unsigned wrap makes addresses below the base land far above the size.
    function automatic logic in_region(input logic [24:0] addr,
                                       input logic [24:0] base,
                                       input logic [24:0] size);
        return (addr - base) < size;
    endfunction

endpackage

// File: rtl/rom_region_dec.sv
// Combinational decode of an image byte address into its ROM region,
// returning a hit flag, a one-hot region select and the region-relative offset.
module rom_region_dec
    import rom_dl_pkg::*;
#(
    parameter int ADDR_W = 17
) (
    input  logic [24:0]            i_addr,
    output logic                   o_hit,
    output logic [NUM_REGIONS-1:0] o_region,
    output logic [ADDR_W-1:0]      o_offset
);

    always_comb begin
        o_region = '0;
        o_offset = '0;
        if (in_region(i_addr, PROG_BASE, PROG_SIZE)) begin
            o_region[REG_PROG] = 1'b1;
            o_offset           = ADDR_W'(i_addr - PROG_BASE);
        end else if (in_region(i_addr, PF_BASE, PF_SIZE)) begin
            o_region[REG_PF] = 1'b1;
            o_offset         = ADDR_W'(i_addr - PF_BASE);
        end else if (in_region(i_addr, MOB_BASE, MOB_SIZE)) begin
            o_region[REG_MOB] = 1'b1;
            o_offset          = ADDR_W'(i_addr - MOB_BASE);
        end else if (in_region(i_addr, PROM_BASE, PROM_SIZE)) begin
            o_region[REG_PROM] = 1'b1;
            o_offset           = ADDR_W'(i_addr - PROM_BASE);
        end
    end

    assign o_hit = |o_region;

endmodule

// File: rtl/rom_dl_ctrl.sv
// ROM download sequencer: forwards ioctl bytes to the four sprint1 ROM regions,
// validates the finished image and gates the core reset until it is usable.
module rom_dl_ctrl
    import rom_dl_pkg::*;
#(
    parameter int ADDR_W      = 17,
    parameter int HOLD_CYCLES = 1024,
    parameter int CNT_W       = 17
) (
    input  logic              clk_sys,
    input  logic              Reset_n,
    input  logic              ioctl_download,
    input  logic              ioctl_wr,
    input  logic [24:0]       ioctl_addr,
    input  logic [7:0]        ioctl_dout,
    input  logic              user_reset,
    output logic              core_reset_n,
    output logic [ADDR_W-1:0] dn_addr,
    output logic [7:0]        dn_data,
    output logic [3:0]        dn_we,
    output logic              rom_ready,
    output logic              dl_error,
    output logic [CNT_W-1:0]  byte_count,
    output dl_state_t         o_dbg_state
);

    localparam int HC_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [HC_W-1:0] HOLD_START = HC_W'(HOLD_CYCLES - 1);

    dl_state_t               r_state;
    dl_state_t               w_state_next;
    logic [HC_W-1:0]         r_hold_cnt;
    logic [HC_W-1:0]         w_hold_next;
    logic                    r_stray;
    logic                    r_dl_armed;
    logic                    r_core_reset_n;
    logic                    r_rom_ready;
    logic                    r_dl_error;
    logic [CNT_W-1:0]        r_byte_count;
    logic [3:0]              r_dn_we;
    logic [ADDR_W-1:0]       r_dn_addr;
    logic [7:0]              r_dn_data;

    logic                    w_hit;
    logic [NUM_REGIONS-1:0]  w_region;
    logic [ADDR_W-1:0]       w_offset;
    logic                    w_accept;
    logic                    w_load_entry;
    logic                    w_run_stay;
    logic                    w_check_fail;

    rom_region_dec #(
        .ADDR_W(ADDR_W)
    ) u_region_dec (
        .i_addr  (ioctl_addr),
        .o_hit   (w_hit),
        .o_region(w_region),
        .o_offset(w_offset)
    );

    // ioctl_wr is a single-cycle strobe with no back-pressure: a byte is taken
    // on every clk_sys edge where ioctl_wr=1 and the FSM is in LOAD.
    assign w_accept     = (r_state == ST_LOAD) && ioctl_wr;
    assign w_load_entry = (w_state_next == ST_LOAD) && (r_state != ST_LOAD);
    assign w_run_stay   = (r_state == ST_RUN) && (w_state_next == ST_RUN);
    assign w_check_fail = (r_state == ST_CHECK) && (w_state_next == ST_FAIL);

    always_comb begin
        w_state_next = r_state;
        w_hold_next  = r_hold_cnt;
        case (r_state)
            // After a reset the download line must be seen low once, so a
            // download interrupted by Reset_n is not resumed half-way.
            ST_EMPTY: begin
                if (ioctl_download && r_dl_armed) begin
                    w_state_next = ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (!ioctl_download) begin
                    w_state_next = ST_CHECK;
                end
            end
            ST_CHECK: begin
                if ((r_byte_count == CNT_W'(TOTAL_BYTES)) && !r_stray) begin
                    w_state_next = ST_HOLD;
                    w_hold_next  = HOLD_START;
                end else begin
                    w_state_next = ST_FAIL;
                end
            end
            ST_HOLD: begin
                if (ioctl_download) begin
                    w_state_next = ST_LOAD;
                end else if (user_reset) begin
                    w_hold_next = HOLD_START;
                end else if (r_hold_cnt == '0) begin
                    w_state_next = ST_RUN;
                end else begin
                    w_hold_next = r_hold_cnt - HC_W'(1);
                end
            end
            ST_RUN: begin
                if (ioctl_download) begin
                    w_state_next = ST_LOAD;
                end else if (user_reset) begin
                    w_state_next = ST_HOLD;
                    w_hold_next  = HOLD_START;
                end
            end
            ST_FAIL: begin
                if (ioctl_download) begin
                    w_state_next = ST_LOAD;
                end
            end
            default: begin
                w_state_next = ST_EMPTY;
            end
        endcase
    end

    always_ff @(posedge clk_sys) begin
        if (!Reset_n) begin
            r_state        <= ST_EMPTY;
            r_hold_cnt     <= '0;
            r_stray        <= 1'b0;
            r_dl_armed     <= 1'b0;
            r_core_reset_n <= 1'b0;
            r_rom_ready    <= 1'b0;
            r_dl_error     <= 1'b0;
            r_byte_count   <= '0;
            r_dn_we        <= '0;
            r_dn_addr      <= '0;
            r_dn_data      <= '0;
        end else begin
            r_state        <= w_state_next;
            r_hold_cnt     <= w_hold_next;
            r_dl_armed     <= r_dl_armed | ~ioctl_download;
            r_dn_we        <= '0;
            // The core only leaves reset once RUN has been held for a cycle.
            r_core_reset_n <= w_run_stay;

            if (w_accept) begin
                if (w_hit) begin
                    r_dn_we   <= w_region;
                    r_dn_addr <= w_offset;
                    r_dn_data <= ioctl_dout;
                    if (r_byte_count != '1) begin
                        r_byte_count <= r_byte_count + CNT_W'(1);
                    end
                end else begin
                    r_stray <= 1'b1;
                end
            end

            if (w_load_entry) begin
                r_byte_count <= '0;
                r_stray      <= 1'b0;
                r_rom_ready  <= 1'b0;
                r_dl_error   <= 1'b0;
            end

            if (w_run_stay) begin
                r_rom_ready <= 1'b1;
            end

            if (w_check_fail) begin
                r_dl_error <= 1'b1;
            end
        end
    end

    assign core_reset_n = r_core_reset_n;
    assign dn_addr      = r_dn_addr;
    assign dn_data      = r_dn_data;
    assign dn_we        = r_dn_we;
    assign rom_ready    = r_rom_ready;
    assign dl_error     = r_dl_error;
    assign byte_count   = r_byte_count;
    assign o_dbg_state  = r_state;

endmodule

// File: tb/tb_rom_dl_ctrl.sv
// Self-checking bench for rom_dl_ctrl: region-decode vector table plus
// directed full/short/stray/reload/user-reset/mid-download-reset sequences.
module tb_rom_dl_ctrl;
    import rom_dl_pkg::*;

    localparam int HC     = 32;
    localparam int ADDR_W = 17;
    localparam int CNT_W  = 17;
    localparam int TOTAL  = 'h3200;

    logic              clk_sys = 1'b0;
    logic              Reset_n;
    logic              ioctl_download;
    logic              ioctl_wr;
    logic [24:0]       ioctl_addr;
    logic [7:0]        ioctl_dout;
    logic              user_reset;
    logic              core_reset_n;
    logic [ADDR_W-1:0] dn_addr;
    logic [7:0]        dn_data;
    logic [3:0]        dn_we;
    logic              rom_ready;
    logic              dl_error;
    logic [CNT_W-1:0]  byte_count;
    dl_state_t         dbg_state;

    rom_dl_ctrl #(
        .ADDR_W     (ADDR_W),
        .HOLD_CYCLES(HC),
        .CNT_W      (CNT_W)
    ) dut (
        .clk_sys       (clk_sys),
        .Reset_n       (Reset_n),
        .ioctl_download(ioctl_download),
        .ioctl_wr      (ioctl_wr),
        .ioctl_addr    (ioctl_addr),
        .ioctl_dout    (ioctl_dout),
        .user_reset    (user_reset),
        .core_reset_n  (core_reset_n),
        .dn_addr       (dn_addr),
        .dn_data       (dn_data),
        .dn_we         (dn_we),
        .rom_ready     (rom_ready),
        .dl_error      (dl_error),
        .byte_count    (byte_count),
        .o_dbg_state   (dbg_state)
    );

    always #5 clk_sys = ~clk_sys;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [28:0] exp_q[$];
    int          region_cnt[4];
    int          bad_beats;
    int          cycles;
    int          seen;

    typedef struct {
        logic        wr;
        logic [24:0] addr;
        logic [7:0]  data;
        logic [3:0]  we;
        logic [16:0] off;
        logic [16:0] cnt;
    } vec_t;
    vec_t vecs[12];

    task automatic step();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] pat(input logic [24:0] a);
        return a[7:0] ^ a[15:8] ^ 8'h5A;
    endfunction

    // Independent region model: {we, offset, data}, we=0 for stray bytes.
    function automatic logic [28:0] exp_write(input logic [24:0] a, input logic [7:0] d);
        logic [3:0]  we;
        logic [24:0] off;
        we  = 4'b0000;
        off = 25'h0;
        if (a <= 25'h1FFF) begin
            we = 4'b0001; off = a;
        end else if (a <= 25'h27FF) begin
            we = 4'b0010; off = a - 25'h2000;
        end else if (a <= 25'h2FFF) begin
            we = 4'b0100; off = a - 25'h2800;
        end else if (a <= 25'h31FF) begin
            we = 4'b1000; off = a - 25'h3000;
        end
        return {we, off[16:0], d};
    endfunction

    task automatic check_reset_values(input string tag);
        check({tag, "_core_reset_n"}, 32'(core_reset_n), 32'd0);
        check({tag, "_dn_we"},        32'(dn_we),        32'd0);
        check({tag, "_dn_addr"},      32'(dn_addr),      32'd0);
        check({tag, "_dn_data"},      32'(dn_data),      32'd0);
        check({tag, "_rom_ready"},    32'(rom_ready),    32'd0);
        check({tag, "_dl_error"},     32'(dl_error),     32'd0);
        check({tag, "_byte_count"},   32'(byte_count),   32'd0);
        check({tag, "_state"},        32'(dbg_state),    32'(ST_EMPTY));
    endtask

    // Streams n sequential bytes (plus an optional stray byte last); the final
    // byte is written in the same cycle ioctl_download falls.
    task automatic load_image(input string tag, input int n, input bit with_stray,
                              input logic [24:0] stray_addr);
        int          total;
        logic [24:0] a;
        logic [28:0] exp;
        logic [28:0] act;
        total = n + (with_stray ? 1 : 0);
        for (int r = 0; r < 4; r++) region_cnt[r] = 0;
        bad_beats = 0;
        exp_q.delete();
        ioctl_download = 1'b1;
        ioctl_wr       = 1'b0;
        step();
        check({tag, "_entry_state"}, 32'(dbg_state),    32'(ST_LOAD));
        check({tag, "_entry_count"}, 32'(byte_count),   32'd0);
        check({tag, "_entry_ready"}, 32'(rom_ready),    32'd0);
        check({tag, "_entry_core"},  32'(core_reset_n), 32'd0);
        check({tag, "_entry_err"},   32'(dl_error),     32'd0);
        for (int i = 0; i < total; i++) begin
            a = (with_stray && i == total - 1) ? stray_addr : 25'(i);
            ioctl_wr   = 1'b1;
            ioctl_addr = a;
            ioctl_dout = pat(a);
            if (i == total - 1) ioctl_download = 1'b0;
            exp_q.push_back(exp_write(a, pat(a)));
            step();
            ioctl_wr = 1'b0;
            exp = exp_q.pop_front();
            act = {dn_we, dn_addr, dn_data};
            if (exp[28:25] == 4'b0000) begin
                if (dn_we != 4'b0000) bad_beats++;
            end else if (act !== exp) begin
                bad_beats++;
            end
            for (int r = 0; r < 4; r++) if (dn_we[r]) region_cnt[r]++;
        end
        check({tag, "_bad_beats"},  32'(bad_beats),  32'd0);
        check({tag, "_post_state"}, 32'(dbg_state),  32'(ST_CHECK));
    endtask

    task automatic wait_release(output int n);
        n = 0;
        while (core_reset_n !== 1'b1 && n < HC + 64) begin
            step();
            n++;
        end
    endtask

    initial begin
        vecs[0]  = '{1'b1, 25'h0000000, 8'h11, 4'b0001, 17'h0000, 17'd1};
        vecs[1]  = '{1'b1, 25'h0001FFF, 8'h22, 4'b0001, 17'h1FFF, 17'd2};
        vecs[2]  = '{1'b1, 25'h0002000, 8'h33, 4'b0010, 17'h0000, 17'd3};
        vecs[3]  = '{1'b1, 25'h00027FF, 8'h44, 4'b0010, 17'h07FF, 17'd4};
        vecs[4]  = '{1'b0, 25'h0002800, 8'h55, 4'b0000, 17'h0000, 17'd4};
        vecs[5]  = '{1'b1, 25'h0002800, 8'h66, 4'b0100, 17'h0000, 17'd5};
        vecs[6]  = '{1'b1, 25'h0002FFF, 8'h77, 4'b0100, 17'h07FF, 17'd6};
        vecs[7]  = '{1'b1, 25'h0003000, 8'h88, 4'b1000, 17'h0000, 17'd7};
        vecs[8]  = '{1'b1, 25'h00031FF, 8'h99, 4'b1000, 17'h01FF, 17'd8};
        vecs[9]  = '{1'b1, 25'h0003200, 8'hAA, 4'b0000, 17'h0000, 17'd8};
        vecs[10] = '{1'b1, 25'h1FFFFFF, 8'hBB, 4'b0000, 17'h0000, 17'd8};
        vecs[11] = '{1'b1, 25'h0001FFF, 8'hCC, 4'b0001, 17'h1FFF, 17'd9};

        Reset_n        = 1'b0;
        ioctl_download = 1'b0;
        ioctl_wr       = 1'b0;
        ioctl_addr     = '0;
        ioctl_dout     = '0;
        user_reset     = 1'b0;
        repeat (3) step();
        check_reset_values("rst");
        Reset_n = 1'b1;

        // Write strobe in EMPTY with no download is ignored.
        ioctl_wr = 1'b1; ioctl_addr = 25'h10; ioctl_dout = 8'hEE;
        step();
        ioctl_wr = 1'b0;
        check("empty_wr_we",    32'(dn_we),      32'd0);
        check("empty_wr_count", 32'(byte_count), 32'd0);
        check("empty_state",    32'(dbg_state),  32'(ST_EMPTY));

        // Region-decode boundary table.
        ioctl_download = 1'b1;
        step();
        check("tbl_entry_state", 32'(dbg_state), 32'(ST_LOAD));
        for (int i = 0; i < 12; i++) begin
            ioctl_wr   = vecs[i].wr;
            ioctl_addr = vecs[i].addr;
            ioctl_dout = vecs[i].data;
            step();
            check($sformatf("vec%0d_we", i), 32'(dn_we), 32'(vecs[i].we));
            if (vecs[i].we != 4'b0000) begin
                check($sformatf("vec%0d_addr", i), 32'(dn_addr), 32'(vecs[i].off));
                check($sformatf("vec%0d_data", i), 32'(dn_data), 32'(vecs[i].data));
            end
            check($sformatf("vec%0d_count", i), 32'(byte_count), 32'(vecs[i].cnt));
        end
        ioctl_wr = 1'b0; ioctl_download = 1'b0;
        step();
        step();
        check("tbl_state_fail", 32'(dbg_state),    32'(ST_FAIL));
        check("tbl_dl_error",   32'(dl_error),     32'd1);
        check("tbl_core",       32'(core_reset_n), 32'd0);

        // Full valid image.
        load_image("full", TOTAL, 1'b0, 25'h0);
        check("full_prog_cnt", 32'(region_cnt[0]), 32'd8192);
        check("full_pf_cnt",   32'(region_cnt[1]), 32'd2048);
        check("full_mob_cnt",  32'(region_cnt[2]), 32'd2048);
        check("full_prom_cnt", 32'(region_cnt[3]), 32'd512);
        check("full_count",    32'(byte_count),    32'h3200);
        wait_release(cycles);
        check("full_release_latency", 32'(cycles), 32'(HC + 2));
        check("full_rom_ready", 32'(rom_ready), 32'd1);
        check("full_dl_error",  32'(dl_error),  32'd0);
        check("full_state_run", 32'(dbg_state), 32'(ST_RUN));

        // Writes with ioctl_download low in RUN are ignored.
        seen = 0;
        for (int i = 0; i < 4; i++) begin
            ioctl_wr = 1'b1; ioctl_addr = 25'(16 + i); ioctl_dout = 8'h3C;
            step();
            if (dn_we != 4'b0000) seen++;
        end
        ioctl_wr = 1'b0;
        check("run_wr_ignored", 32'(seen),       32'd0);
        check("run_wr_count",   32'(byte_count), 32'h3200);

        // User reset pulse of 5 cycles in RUN.
        user_reset = 1'b1;
        step();
        check("ur_core_low",   32'(core_reset_n), 32'd0);
        check("ur_state_hold", 32'(dbg_state),    32'(ST_HOLD));
        repeat (4) step();
        user_reset = 1'b0;
        wait_release(cycles);
        check("ur_release_latency", 32'(cycles),    32'(HC + 1));
        check("ur_rom_ready",       32'(rom_ready), 32'd1);

        // Second download from RUN, valid reload.
        load_image("reload", TOTAL, 1'b0, 25'h0);
        check("reload_count", 32'(byte_count), 32'h3200);
        wait_release(cycles);
        check("reload_release_latency", 32'(cycles),    32'(HC + 2));
        check("reload_rom_ready",       32'(rom_ready), 32'd1);

        // Short image, one byte missing.
        load_image("short", TOTAL - 1, 1'b0, 25'h0);
        check("short_count",    32'(byte_count),    32'h31FF);
        check("short_prom_cnt", 32'(region_cnt[3]), 32'd511);
        step();
        check("short_state", 32'(dbg_state), 32'(ST_FAIL));
        check("short_err",   32'(dl_error),  32'd1);
        seen = 0;
        for (int i = 0; i < 3 * HC + 20; i++) begin
            step();
            if (core_reset_n !== 1'b0 || rom_ready !== 1'b0) seen++;
        end
        check("short_held_in_reset", 32'(seen), 32'd0);

        // Valid count plus a stray byte at 0x4000.
        load_image("stray", TOTAL, 1'b1, 25'h4000);
        check("stray_count", 32'(byte_count), 32'h3200);
        step();
        check("stray_state", 32'(dbg_state), 32'(ST_FAIL));
        check("stray_err",   32'(dl_error),  32'd1);
        check("stray_ready", 32'(rom_ready), 32'd0);

        // Reset_n mid-download after 100 writes.
        ioctl_download = 1'b1;
        step();
        check("mid_entry_state", 32'(dbg_state), 32'(ST_LOAD));
        seen = 0;
        for (int i = 0; i < 100; i++) begin
            ioctl_wr = 1'b1; ioctl_addr = 25'(i); ioctl_dout = pat(25'(i));
            step();
            if (dn_we != 4'b0000) seen++;
        end
        check("mid_we_beats", 32'(seen),       32'd100);
        check("mid_count",    32'(byte_count), 32'd100);
        Reset_n = 1'b0; ioctl_addr = 25'd100; ioctl_dout = pat(25'd100);
        step();
        check_reset_values("mid_rst");
        Reset_n = 1'b1;
        seen = 0;
        for (int i = 101; i < 131; i++) begin
            ioctl_wr = 1'b1; ioctl_addr = 25'(i); ioctl_dout = pat(25'(i));
            step();
            if (dn_we != 4'b0000 || byte_count != '0 || dbg_state != ST_EMPTY) seen++;
        end
        check("mid_ignored", 32'(seen), 32'd0);
        ioctl_wr = 1'b0; ioctl_download = 1'b0;
        step();
        step();
        load_image("restart", TOTAL, 1'b0, 25'h0);
        check("restart_count", 32'(byte_count), 32'h3200);
        wait_release(cycles);
        check("restart_release_latency", 32'(cycles),    32'(HC + 2));
        check("restart_rom_ready",       32'(rom_ready), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
